// File: rtl/prime_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prime_pkg
// Purpose  : Shared width and state encodings for the prime range scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package prime_pkg;

    localparam int WIDTH = 8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TEST = 3'd1,
        S_WAIT = 3'd2,
        S_EMIT = 3'd3,
        S_NEXT = 3'd4,
        S_DONE = 3'd5
    } sched_state_e;

    typedef enum logic [0:0] {
        E_IDLE = 1'b0,
        E_RUN  = 1'b1
    } eng_state_e;

endpackage
`default_nettype wire

// File: rtl/prime_trial_engine.sv
`default_nettype none
// ============================================================================
// Module   : prime_trial_engine
// Purpose  : Iterative trial-division primality test, one divisor per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module prime_trial_engine #(
    parameter int WIDTH = prime_pkg::WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             eng_start_i,
    input  logic [WIDTH-1:0] n_i,
    output logic             eng_valid_o,
    output logic             eng_prime_o
);
    import prime_pkg::*;

    eng_state_e         state_q, state_d;
    logic [WIDTH-1:0]   n_q, n_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic               valid_q, valid_d;
    logic               prime_q, prime_d;
    logic [2*WIDTH-1:0] sq;
    logic [WIDTH-1:0]   rem;

    // Square at double width so the d*d > n test can never overflow.
    assign sq  = {{WIDTH{1'b0}}, d_q} * {{WIDTH{1'b0}}, d_q};
    assign rem = n_q % d_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= E_IDLE;
            n_q     <= '0;
            d_q     <= WIDTH'(2);
            valid_q <= 1'b0;
            prime_q <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            d_q     <= d_d;
            valid_q <= valid_d;
            prime_q <= prime_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        d_d     = d_q;
        valid_d = 1'b0;
        prime_d = prime_q;
        if (eng_start_i) begin
            // A new load also discards any result still in flight.
            state_d = E_RUN;
            n_d     = n_i;
            d_d     = WIDTH'(2);
        end else if (state_q == E_RUN) begin
            if (n_q < WIDTH'(2)) begin
                valid_d = 1'b1;
                prime_d = 1'b0;
                state_d = E_IDLE;
            end else if (sq > {{WIDTH{1'b0}}, n_q}) begin
                valid_d = 1'b1;
                prime_d = 1'b1;
                state_d = E_IDLE;
            end else if (rem == '0) begin
                valid_d = 1'b1;
                prime_d = 1'b0;
                state_d = E_IDLE;
            end else begin
                d_d = d_q + WIDTH'(1);
            end
        end
    end

    assign eng_valid_o = valid_q;
    assign eng_prime_o = prime_q;

endmodule
`default_nettype wire

// File: rtl/prime_range_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : prime_range_scheduler
// Purpose  : Scans [lo, hi], tests each value and streams primes via valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module prime_range_scheduler #(
    parameter int WIDTH = prime_pkg::WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] hi_i,
    output logic             busy_o,
    output logic             prime_valid_o,
    input  logic             prime_ready_i,
    output logic [WIDTH-1:0] prime_data_o,
    output logic [WIDTH-1:0] prime_count_o,
    output logic             done_o,
    output logic             err_o
);
    import prime_pkg::*;

    sched_state_e     state_q, state_d;
    logic [WIDTH-1:0] cur_q, cur_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             eng_start;
    logic             eng_valid;
    logic             eng_prime;

    prime_trial_engine #(.WIDTH(WIDTH)) u_engine (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .eng_start_i (eng_start),
        .n_i         (cur_q),
        .eng_valid_o (eng_valid),
        .eng_prime_o (eng_prime)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cur_q   <= '0;
            last_q  <= '0;
            count_q <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cur_q   <= cur_d;
            last_q  <= last_d;
            count_q <= count_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        last_d    = last_q;
        count_d   = count_q;
        data_d    = data_q;
        eng_start = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (lo_i <= hi_i) begin
                        cur_d   = lo_i;
                        last_d  = hi_i;
                        count_d = '0;
                        state_d = S_TEST;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_TEST: begin
                eng_start = !abort_i;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (eng_valid) begin
                    state_d = eng_prime ? S_EMIT : S_NEXT;
                    if (eng_prime) begin
                        data_d = cur_q;
                    end
                end
            end
            S_EMIT: begin
                if (prime_ready_i) begin
                    count_d = count_q + WIDTH'(1);
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                // Compare before increment so hi at full scale never wraps.
                if (cur_q == last_q) begin
                    state_d = S_DONE;
                end else begin
                    cur_d   = cur_q + WIDTH'(1);
                    state_d = S_TEST;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort_i && state_q != S_IDLE) begin
            state_d = S_IDLE;
            count_d = count_q;
        end

        busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
        valid_d = (state_d == S_EMIT);
        done_d  = (state_d == S_DONE);
    end

    assign busy_o        = busy_q;
    assign prime_valid_o = valid_q;
    assign prime_data_o  = data_q;
    assign prime_count_o = count_q;
    assign done_o        = done_q;
    assign err_o         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_prime_range_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_prime_range_scheduler
// Purpose  : Directed self-checking bench for prime_range_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prime_range_scheduler;
    import prime_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       start_i;
    logic       abort_i;
    logic [7:0] lo_i;
    logic [7:0] hi_i;
    logic       busy_o;
    logic       prime_valid_o;
    logic       prime_ready_i;
    logic [7:0] prime_data_o;
    logic [7:0] prime_count_o;
    logic       done_o;
    logic       err_o;

    int n_chk  = 0;
    int n_pass = 0;
    int valid_cnt;
    int done_cnt;
    int got_q[$];
    int exp_q[$];

    prime_range_scheduler dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .lo_i          (lo_i),
        .hi_i          (hi_i),
        .busy_o        (busy_o),
        .prime_valid_o (prime_valid_o),
        .prime_ready_i (prime_ready_i),
        .prime_data_o  (prime_data_o),
        .prime_count_o (prime_count_o),
        .done_o        (done_o),
        .err_o         (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Record accepted handshakes and pulse counts away from the active edge.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (prime_valid_o && prime_ready_i && !abort_i) got_q.push_back(int'(prime_data_o));
            if (prime_valid_o) valid_cnt++;
            if (done_o) done_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr();
        got_q.delete();
        valid_cnt = 0;
        done_cnt  = 0;
    endtask

    task automatic pulse_start(input logic [7:0] lo, input logic [7:0] hi);
        start_i = 1'b1;
        lo_i    = lo;
        hi_i    = hi;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            if (done_o) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_busy_at_done"}, 32'(busy_o), 32'd0);
        tick();
        tick();
    endtask

    task automatic wait_valid(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            if (prime_valid_o) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_valid_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic check_seq(input string tag);
        chk({tag, "_nprimes"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_prime%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        rst_ni        = 1'b0;
        start_i       = 1'b0;
        abort_i       = 1'b0;
        lo_i          = '0;
        hi_i          = '0;
        prime_ready_i = 1'b1;
        clr();
        #3;
        chk("rst_busy",  32'(busy_o),        32'd0);
        chk("rst_valid", 32'(prime_valid_o), 32'd0);
        chk("rst_data",  32'(prime_data_o),  32'd0);
        chk("rst_count", 32'(prime_count_o), 32'd0);
        chk("rst_done",  32'(done_o),        32'd0);
        chk("rst_err",   32'(err_o),         32'd0);
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        tick();

        // Range 0..10
        clr();
        exp_q = '{2, 3, 5, 7};
        pulse_start(8'd0, 8'd10);
        chk("s0_busy_next", 32'(busy_o), 32'd1);
        wait_done("s0", 500);
        check_seq("s0");
        chk("s0_count", 32'(prime_count_o), 32'd4);
        chk("s0_ndone", 32'(done_cnt), 32'd1);

        // Single prime, with a start issued while busy that must be ignored
        clr();
        exp_q = '{79};
        pulse_start(8'd79, 8'd79);
        tick();
        tick();
        pulse_start(8'd100, 8'd100);
        wait_done("s79", 500);
        check_seq("s79");
        chk("s79_count", 32'(prime_count_o), 32'd1);
        chk("s79_ndone", 32'(done_cnt), 32'd1);

        // Single composite
        clr();
        pulse_start(8'd100, 8'd100);
        wait_done("s100", 500);
        chk("s100_nvalid", 32'(valid_cnt), 32'd0);
        chk("s100_count", 32'(prime_count_o), 32'd0);
        chk("s100_ndone", 32'(done_cnt), 32'd1);

        // Top of range, no wrap
        clr();
        exp_q = '{251};
        pulse_start(8'd250, 8'd255);
        wait_done("s250", 1000);
        repeat (5) tick();
        check_seq("s250");
        chk("s250_count", 32'(prime_count_o), 32'd1);
        chk("s250_ndone", 32'(done_cnt), 32'd1);
        chk("s250_busy_after", 32'(busy_o), 32'd0);

        // Full range
        clr();
        pulse_start(8'd0, 8'd255);
        wait_done("sfull", 20000);
        chk("sfull_nprimes", 32'(got_q.size()), 32'd54);
        if (got_q.size() > 0) chk("sfull_last", 32'(got_q[got_q.size()-1]), 32'd251);
        else chk("sfull_last", 32'd0, 32'd251);
        chk("sfull_count", 32'(prime_count_o), 32'd54);

        // Backpressure on 23
        clr();
        exp_q = '{23, 29};
        prime_ready_i = 1'b0;
        pulse_start(8'd20, 8'd30);
        wait_valid("bp", 500);
        chk("bp_first", 32'(prime_data_o), 32'd23);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk($sformatf("bp_hold_valid%0d", i), 32'(prime_valid_o), 32'd1);
            chk($sformatf("bp_hold_data%0d", i), 32'(prime_data_o), 32'd23);
        end
        @(posedge clk_i);
        #1 prime_ready_i = 1'b1;
        wait_done("bp", 500);
        check_seq("bp");
        chk("bp_count", 32'(prime_count_o), 32'd2);

        // lo > hi rejected
        clr();
        pulse_start(8'd20, 8'd10);
        chk("err_pulse", 32'(err_o), 32'd1);
        chk("err_busy", 32'(busy_o), 32'd0);
        tick();
        chk("err_one_cycle", 32'(err_o), 32'd0);
        repeat (3) tick();
        chk("err_ndone", 32'(done_cnt), 32'd0);
        chk("err_count_kept", 32'(prime_count_o), 32'd2);

        // Abort while testing 56
        clr();
        exp_q = '{53};
        pulse_start(8'd50, 8'd60);
        begin
            bit found = 1'b0;
            for (int i = 0; i < 2000; i++) begin
                @(negedge clk_i);
                if (dut.state_q == S_WAIT && dut.cur_q == 8'd56) begin
                    found = 1'b1;
                    break;
                end
            end
            chk("ab_reach56", 32'(found), 32'd1);
        end
        @(posedge clk_i);
        #1 abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("ab_busy", 32'(busy_o), 32'd0);
        chk("ab_valid", 32'(prime_valid_o), 32'd0);
        repeat (5) tick();
        chk("ab_ndone", 32'(done_cnt), 32'd0);
        chk("ab_count", 32'(prime_count_o), 32'd1);
        check_seq("ab");

        // Abort and ready together in EMIT
        clr();
        prime_ready_i = 1'b0;
        pulse_start(8'd2, 8'd3);
        wait_valid("abr", 500);
        @(posedge clk_i);
        #1;
        abort_i       = 1'b1;
        prime_ready_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("abr_count", 32'(prime_count_o), 32'd0);
        chk("abr_valid", 32'(prime_valid_o), 32'd0);
        chk("abr_busy", 32'(busy_o), 32'd0);
        repeat (3) tick();
        chk("abr_ndone", 32'(done_cnt), 32'd0);
        chk("abr_nprimes", 32'(got_q.size()), 32'd0);

        // Reset while 29 is presented (count already 1)
        clr();
        prime_ready_i = 1'b1;
        pulse_start(8'd20, 8'd30);
        wait_valid("rm23", 500);
        @(posedge clk_i);
        #1 prime_ready_i = 1'b0;
        wait_valid("rm29", 500);
        chk("rm_pre_data", 32'(prime_data_o), 32'd29);
        chk("rm_pre_count", 32'(prime_count_o), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("rm_busy",  32'(busy_o),        32'd0);
        chk("rm_valid", 32'(prime_valid_o), 32'd0);
        chk("rm_data",  32'(prime_data_o),  32'd0);
        chk("rm_count", 32'(prime_count_o), 32'd0);
        chk("rm_done",  32'(done_o),        32'd0);
        chk("rm_err",   32'(err_o),         32'd0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        repeat (3) tick();
        chk("rm_idle_busy", 32'(busy_o), 32'd0);
        chk("rm_idle_valid", 32'(prime_valid_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prime_range_scheduler.md
# prime_range_scheduler

Sequential controller that scans an inclusive 8-bit range [lo, hi], tests each candidate for primality with an iterative trial-division engine, and streams every prime found over a valid/ready interface. It sits between a host-side command source and downstream consumers of prime values. It also keeps a running prime count for the scan.

## Interface

- WIDTH, 8, candidate/data width in bits
- clk  in  1  system clock, rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  single-cycle scan request; honoured only when busy=0
- abort  in  1  synchronous abort of the scan in progress
- lo  in  WIDTH  range lower bound, sampled on an accepted start
- hi  in  WIDTH  range upper bound, inclusive, sampled on an accepted start
- busy  out  1  scan in progress
- prime_valid  out  1  prime_data holds a prime
- prime_ready  in  1  consumer accepts prime_data
- prime_data  out  WIDTH  prime value
- prime_count  out  WIDTH  primes handed off in current/last scan
- done  out  1  one-cycle pulse at normal scan completion
- err  out  1  one-cycle pulse: start rejected because lo > hi

## Operation

- States: IDLE, TEST, WAIT, EMIT, NEXT, DONE.
- IDLE: on start with lo ≤ hi, register cur=lo, end=hi, clear prime_count, set busy, go TEST. If lo > hi, pulse err, stay IDLE, prime_count unchanged. start during busy=1 is ignored.
- TEST: pulse eng_start with n=cur, go WAIT.
- WAIT: on eng_valid, go EMIT if eng_prime, else go NEXT.
- EMIT: prime_valid=1, prime_data=cur, held stable until prime_valid & prime_ready. On the handshake, prime_count += 1 and go NEXT. No duplicates.
- NEXT: if cur == end, go DONE. Otherwise cur += 1 and go TEST. The compare happens before the increment, so hi=255 never wraps.
- DONE: pulse done, clear busy, go IDLE. prime_count holds until the next accepted start.
- Trial engine:
  - Loads n and d=2.
  - Each cycle evaluates, in priority order: n<2 gives not prime; d*d>n gives prime; n mod d==0 gives not prime; otherwise d += 1.
  - d*d is computed at 2*WIDTH bits, so there is no overflow.
- abort (any non-IDLE state): next state IDLE, busy=0, prime_valid=0. No done pulse. An in-flight EMIT is dropped uncounted. prime_count keeps its partial value.

## Timing

- Reset values: busy 0, prime_valid 0, prime_data 0, prime_count 0, done 0, err 0. The FSM resets to IDLE and the engine resets idle.
- All outputs are registered.
- Accepted start at edge t: busy=1 from t+1.
- Engine latency:
  - eng_start at cycle t loads the engine.
  - The first evaluation (d=2) happens in t+1.
  - eng_valid is registered and appears the cycle after the deciding evaluation.
  - n=0/1/2/3: eng_valid at t+2. n=4: t+2. n=79: t+9 (d=2..9). n=251: t+16.
- EMIT is entered the cycle after eng_valid. With prime_ready held at 1, prime_valid is high for exactly one cycle.
- Reset asserted mid-scan forces the reset values immediately (asynchronous). Deassertion leaves the block in IDLE.
- Simultaneous abort and prime_ready in EMIT: abort wins and the count does not increment.
- Simultaneous abort and start: abort acts only when non-IDLE. In IDLE, start is processed normally.

## Structure

- Shared package/include prime_pkg:
  - WIDTH default
  - FSM state encodings (S_IDLE … S_DONE)
  - engine state encodings
- Sub-module prime_trial_engine:
  - Ports: clk, rst, eng_start, n[WIDTH], eng_valid, eng_prime.
  - Owns the divisor counter and the square/modulo datapath.
- The scheduler owns cur, end, prime_count, the handshake and the FSM.

## Test plan

- lo=0, hi=10, prime_ready=1 → prime_data sequence 2, 3, 5, 7; prime_count=4; exactly one done pulse; busy falls with done.
- lo=79, hi=79 → single prime 79, count=1. Then lo=100, hi=100 → no prime_valid, count=0, done pulse.
- lo=250, hi=255 → only 251 emitted, count=1, done, no wrap to 0. Full scan lo=0, hi=255 → count=54, last prime 251.
- Backpressure: lo=20, hi=30, prime_ready low for 5 cycles when 23 is presented → prime_valid/prime_data=23 held stable. Sequence is 23, 29; count=2.
- lo=20, hi=10 → err pulse for 1 cycle, busy stays 0, no done, prime_count unchanged. start during busy → ignored, ranges unchanged.
- Abort during WAIT for n=56 in scan 50..60 → busy=0 next cycle, no done, count=1 (53 only). Reset asserted mid-EMIT → all outputs at reset values immediately.
